stack_alu_seq: RTL and testbench

- Operand sequencer and integer ALU for WebAssembly i32 numeric instructions.
- Sits directly upstream of the operand stack and is its only driver. It takes decoded opcodes from the decoder and turns each one into a short sequence of stack push, pop and replace ops.
- Reads operands only through the stack's top-of-stack output.
- Reports completion with `done`. Raises a sticky `trap` on underflow, overflow or an illegal opcode.

---
 rtl/stack_alu_seq_pkg.sv | 85 ++++++++
 rtl/stack_alu_seq_if.sv | 12 +
 rtl/stack_alu_seq_alu_core.sv | 84 ++++++++
 rtl/stack_alu_seq.sv | 151 +++++++++++++++
 tb/tb_stack_alu_seq.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_alu_seq_pkg.sv
// Shared encodings for the i32 operand sequencer: stack ops, status/error codes, opcodes, traps.
// Optional multiply is enabled by defining STACK_ALU_MUL_EN.
package stack_alu_seq_pkg;

  typedef enum logic [1:0] {
    StkNone    = 2'd0,
    StkPush    = 2'd1,
    StkPop     = 2'd2,
    StkReplace = 2'd3
  } stk_op_e;

  localparam logic [1:0] StatNone     = 2'd0;
  localparam logic [1:0] StatEmpty    = 2'd1;
  localparam logic [1:0] StatFull     = 2'd2;

  localparam logic [1:0] ErrNone      = 2'd0;
  localparam logic [1:0] ErrUnderflow = 2'd1;
  localparam logic [1:0] ErrOverflow  = 2'd2;

  // Trap codes share the stack error encoding so a stack error can be latched directly.
  localparam logic [1:0] TrapNone      = 2'd0;
  localparam logic [1:0] TrapUnderflow = 2'd1;
  localparam logic [1:0] TrapOverflow  = 2'd2;
  localparam logic [1:0] TrapIllegal   = 2'd3;

  localparam logic [7:0] OpDrop   = 8'h1A;
  localparam logic [7:0] OpConst  = 8'h41;
  localparam logic [7:0] OpEqz    = 8'h45;
  localparam logic [7:0] OpEq     = 8'h46;
  localparam logic [7:0] OpNe     = 8'h47;
  localparam logic [7:0] OpLtS    = 8'h48;
  localparam logic [7:0] OpLtU    = 8'h49;
  localparam logic [7:0] OpGtS    = 8'h4A;
  localparam logic [7:0] OpGtU    = 8'h4B;
  localparam logic [7:0] OpClz    = 8'h67;
  localparam logic [7:0] OpCtz    = 8'h68;
  localparam logic [7:0] OpPopcnt = 8'h69;
  localparam logic [7:0] OpAdd    = 8'h6A;
  localparam logic [7:0] OpSub    = 8'h6B;
  localparam logic [7:0] OpMul    = 8'h6C;
  localparam logic [7:0] OpAnd    = 8'h71;
  localparam logic [7:0] OpOr     = 8'h72;
  localparam logic [7:0] OpXor    = 8'h73;
  localparam logic [7:0] OpShl    = 8'h74;
  localparam logic [7:0] OpShrS   = 8'h75;
  localparam logic [7:0] OpShrU   = 8'h76;
  localparam logic [7:0] OpRotl   = 8'h77;
  localparam logic [7:0] OpRotr   = 8'h78;

  typedef enum logic [2:0] {
    ClsConst,
    ClsDrop,
    ClsUnary,
    ClsBinary,
    ClsIllegal
  } op_cls_e;

  typedef enum logic [2:0] {
    StIdle,
    StOne,
    StPopB,
    StExec,
    StRestore,
    StFinish,
    StTrap
  } state_e;

  function automatic op_cls_e op_class(input logic [7:0] op);
    op_cls_e cls;
    case (op)
      OpConst:                          cls = ClsConst;
      OpDrop:                           cls = ClsDrop;
      OpEqz, OpClz, OpCtz, OpPopcnt:    cls = ClsUnary;
      OpEq, OpNe, OpLtS, OpLtU, OpGtS, OpGtU,
      OpAdd, OpSub, OpAnd, OpOr, OpXor,
      OpShl, OpShrS, OpShrU, OpRotl, OpRotr: cls = ClsBinary;
`ifdef STACK_ALU_MUL_EN
      OpMul:                            cls = ClsBinary;
`endif
      default:                          cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/stack_alu_seq_if.sv
// Decoder-to-sequencer command channel: valid/ready handshake carrying opcode and immediate.
interface stack_alu_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [7:0]       cmd_op;
  logic [WIDTH-1:0] cmd_imm;

  modport master (output cmd_valid, output cmd_op, output cmd_imm, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_imm, output cmd_ready);
endinterface

// File: rtl/stack_alu_seq_alu_core.sv
// Combinational i32 ALU: a is top-of-stack (deeper operand for binaries), b is the latched operand.
// Multiply exists only when STACK_ALU_MUL_EN is defined.
module stack_alu_seq_alu_core
  import stack_alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [7:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o
);

  function automatic logic [WIDTH-1:0] count_lz(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + WIDTH'(1);
    end
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] count_tz(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + WIDTH'(1);
    end
    return n;
  endfunction

  function automatic logic [WIDTH-1:0] count_ones(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + WIDTH'(v[i]);
    return n;
  endfunction

  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] dbl_l, dbl_r;

  // Rotates take the matching half of a doubled word shifted by the amount.
  assign sh    = b_i[SHW-1:0];
  assign dbl_l = {a_i, a_i} << sh;
  assign dbl_r = {a_i, a_i} >> sh;

  always_comb begin
    result_o = '0;
    case (op_i)
      OpEqz:    result_o = WIDTH'(a_i == '0);
      OpEq:     result_o = WIDTH'(a_i == b_i);
      OpNe:     result_o = WIDTH'(a_i != b_i);
      OpLtS:    result_o = WIDTH'($signed(a_i) < $signed(b_i));
      OpLtU:    result_o = WIDTH'(a_i < b_i);
      OpGtS:    result_o = WIDTH'($signed(a_i) > $signed(b_i));
      OpGtU:    result_o = WIDTH'(a_i > b_i);
      OpClz:    result_o = count_lz(a_i);
      OpCtz:    result_o = count_tz(a_i);
      OpPopcnt: result_o = count_ones(a_i);
      OpAdd:    result_o = a_i + b_i;
      OpSub:    result_o = a_i - b_i;
`ifdef STACK_ALU_MUL_EN
      OpMul:    result_o = a_i * b_i;
`endif
      OpAnd:    result_o = a_i & b_i;
      OpOr:     result_o = a_i | b_i;
      OpXor:    result_o = a_i ^ b_i;
      OpShl:    result_o = a_i << sh;
      OpShrS:   result_o = $signed(a_i) >>> sh;
      OpShrU:   result_o = a_i >> sh;
      OpRotl:   result_o = dbl_l[2*WIDTH-1:WIDTH];
      OpRotr:   result_o = dbl_r[WIDTH-1:0];
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/stack_alu_seq.sv
// Operand sequencer: turns each accepted i32 opcode into stack push/pop/replace ops.
// Define STACK_ALU_MUL_EN to make 0x6C (mul) legal; otherwise it traps as illegal.
module stack_alu_seq
  import stack_alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  stack_alu_seq_if.slave   cmd_if,
  output logic [1:0]       stk_op_o,
  output logic [WIDTH-1:0] stk_data_o,
  input  logic [WIDTH-1:0] stk_tos_i,
  input  logic [1:0]       stk_status_i,
  input  logic [1:0]       stk_error_i,
  output logic             done_o,
  output logic [1:0]       trap_o
);

  state_e           state_q, state_d;
  logic [7:0]       op_q, op_d;
  logic [WIDTH-1:0] imm_q, imm_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       trap_q, trap_d;
  logic             ready;
  logic [WIDTH-1:0] alu_res;
  op_cls_e          cur_cls, new_cls;

  assign cur_cls = op_class(op_q);
  assign new_cls = op_class(cmd_if.cmd_op);

  stack_alu_seq_alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_alu_core (
    .op_i     (op_q),
    .a_i      (stk_tos_i),
    .b_i      (b_q),
    .result_o (alu_res)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    imm_d      = imm_q;
    b_d        = b_q;
    trap_d     = trap_q;
    ready      = 1'b0;
    done_o     = 1'b0;
    stk_op_o   = StkNone;
    stk_data_o = '0;

    unique case (state_q)
      StIdle: ready = 1'b1;
      StOne: begin
        if (cur_cls == ClsConst) begin
          if (stk_status_i == StatFull) begin
            state_d = StTrap;
            trap_d  = TrapOverflow;
          end else begin
            stk_op_o   = StkPush;
            stk_data_o = imm_q;
            state_d    = StFinish;
          end
        end else if (stk_status_i == StatEmpty) begin
          state_d = StTrap;
          trap_d  = TrapUnderflow;
        end else if (cur_cls == ClsDrop) begin
          stk_op_o = StkPop;
          state_d  = StFinish;
        end else begin
          stk_op_o   = StkReplace;
          stk_data_o = alu_res;
          state_d    = StFinish;
        end
      end
      StPopB: begin
        if (stk_status_i == StatEmpty) begin
          state_d = StTrap;
          trap_d  = TrapUnderflow;
        end else begin
          b_d      = stk_tos_i;
          stk_op_o = StkPop;
          state_d  = StExec;
        end
      end
      StExec: begin
        // Empty here means b was the only operand; put it back before trapping.
        if (stk_status_i == StatEmpty) begin
          state_d = StRestore;
        end else begin
          stk_op_o   = StkReplace;
          stk_data_o = alu_res;
          state_d    = StFinish;
        end
      end
      StRestore: begin
        stk_op_o   = StkPush;
        stk_data_o = b_q;
        state_d    = StTrap;
        trap_d     = TrapUnderflow;
      end
      StFinish: begin
        if (stk_error_i != ErrNone) begin
          state_d = StTrap;
          trap_d  = stk_error_i;
        end else begin
          done_o  = 1'b1;
          ready   = 1'b1;
          state_d = StIdle;
        end
      end
      StTrap: ;
      default: state_d = StIdle;
    endcase

    if (ready && cmd_if.cmd_valid) begin
      op_d  = cmd_if.cmd_op;
      imm_d = cmd_if.cmd_imm;
      case (new_cls)
        ClsConst, ClsDrop, ClsUnary: state_d = StOne;
        ClsBinary:                   state_d = StPopB;
        default: begin
          state_d = StTrap;
          trap_d  = TrapIllegal;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= '0;
      imm_q   <= '0;
      b_q     <= '0;
      trap_q  <= TrapNone;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      b_q     <= b_d;
      trap_q  <= trap_d;
    end
  end

  assign cmd_if.cmd_ready = ready;
  assign trap_o           = trap_q;

endmodule

// File: tb/tb_stack_alu_seq.sv
// Self-checking bench: behavioural operand stack, queue-based reference model, vector table,
// hand-written corner sequences and randomized command streams.
module tb_stack_alu_seq;
  import stack_alu_seq_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 8;
`ifdef STACK_ALU_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   stk_op, stk_status, stk_error, trap;
  logic [W-1:0] stk_data, stk_tos;
  logic         done;
  logic         stk_clr = 1'b1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stack_alu_seq_if #(.WIDTH(W)) cmd_if ();

  stack_alu_seq #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_if       (cmd_if),
    .stk_op_o     (stk_op),
    .stk_data_o   (stk_data),
    .stk_tos_i    (stk_tos),
    .stk_status_i (stk_status),
    .stk_error_i  (stk_error),
    .done_o       (done),
    .trap_o       (trap)
  );

  // Behavioural operand stack driven by the DUT
  logic [W-1:0] mem [DEPTH];
  int sp = 0;

  always @(posedge clk) begin
    if (stk_clr) begin
      sp        <= 0;
      stk_error <= ErrNone;
    end else begin
      stk_error <= ErrNone;
      case (stk_op)
        StkPush:    if (sp == DEPTH) stk_error <= ErrOverflow;
                    else begin mem[sp] <= stk_data; sp <= sp + 1; end
        StkPop:     if (sp == 0) stk_error <= ErrUnderflow; else sp <= sp - 1;
        StkReplace: if (sp == 0) stk_error <= ErrUnderflow; else mem[sp-1] <= stk_data;
        default: ;
      endcase
    end
  end

  assign stk_tos    = (sp > 0) ? mem[sp-1] : '0;
  assign stk_status = (sp == 0) ? StatEmpty : ((sp == DEPTH) ? StatFull : StatNone);

  // Reference model: expected stack contents
  logic [W-1:0] mq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // 0 const, 1 drop, 2 unary, 3 binary, 4 illegal
  function automatic int op_kind(input logic [7:0] op);
    if (op == 8'h41) return 0;
    if (op == 8'h1A) return 1;
    if (op inside {8'h45, 8'h67, 8'h68, 8'h69}) return 2;
    if (op inside {[8'h46:8'h4B], 8'h6A, 8'h6B, [8'h71:8'h78]}) return 3;
    if (MulEn && op == 8'h6C) return 3;
    return 4;
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [7:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int           sh = int'(b % W);
    int           n = 0;
    logic [W-1:0] t = a;
    case (op)
      8'h45: return {31'b0, a == 0};
      8'h46: return {31'b0, a == b};
      8'h47: return {31'b0, a != b};
      8'h48: return {31'b0, $signed(a) < $signed(b)};
      8'h49: return {31'b0, a < b};
      8'h4A: return {31'b0, $signed(a) > $signed(b)};
      8'h4B: return {31'b0, a > b};
      8'h67: begin
        for (int i = W - 1; i >= 0; i--) begin
          if (a[i]) break;
          n++;
        end
        return 32'(n);
      end
      8'h68: begin
        if (a == 0) return 32'(W);
        while (t % 2 == 0) begin t = t / 2; n++; end
        return 32'(n);
      end
      8'h69: begin
        for (int i = 0; i < W; i++) n += int'(a[i]);
        return 32'(n);
      end
      8'h6A: return a + b;
      8'h6B: return a - b;
      8'h6C: return a * b;
      8'h71: return a & b;
      8'h72: return a | b;
      8'h73: return a ^ b;
      8'h74: return a << sh;
      8'h75: return $signed(a) >>> sh;
      8'h76: return a >> sh;
      8'h77: return (a << sh) | (a >> ((W - sh) % W));
      8'h78: return (a >> sh) | (a << ((W - sh) % W));
      default: return '0;
    endcase
  endfunction

  // Issues one command and checks every cycle up to its retirement or trap.
  task automatic run_cmd(input logic [7:0] op, input logic [W-1:0] imm, output logic trapped);
    logic [1:0]   eop  [1:4];
    logic [W-1:0] edat [1:4];
    logic [1:0]   etrap = TrapNone;
    logic [W-1:0] a, b, r;
    int           len = 2;
    int           w = 0;
    int           depth = mq.size();
    for (int c = 1; c <= 4; c++) begin eop[c] = StkNone; edat[c] = '0; end
    case (op_kind(op))
      0: if (depth == DEPTH) etrap = TrapOverflow;
         else begin eop[1] = StkPush; edat[1] = imm; mq.push_back(imm); end
      1: if (depth == 0) etrap = TrapUnderflow;
         else begin eop[1] = StkPop; void'(mq.pop_back()); end
      2: if (depth == 0) etrap = TrapUnderflow;
         else begin
           eop[1] = StkReplace; edat[1] = ref_alu(op, mq[depth-1], '0);
           mq[depth-1] = edat[1];
         end
      3: if (depth == 0) etrap = TrapUnderflow;
         else if (depth == 1) begin
           eop[1] = StkPop; eop[3] = StkPush; edat[3] = mq[0];
           len = 4; etrap = TrapUnderflow;
         end else begin
           b = mq.pop_back(); a = mq.pop_back(); r = ref_alu(op, a, b); mq.push_back(r);
           eop[1] = StkPop; eop[2] = StkReplace; edat[2] = r; len = 3;
         end
      default: begin len = 1; etrap = TrapIllegal; end
    endcase

    while (!cmd_if.cmd_ready && w < 20) begin @(negedge clk); w++; end
    if (!cmd_if.cmd_ready) begin
      chk($sformatf("op %02h ready timeout", op), 0, 1);
      trapped = 1'b1;
      return;
    end
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_imm   = imm;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    for (int c = 1; c <= len; c++) begin
      chk($sformatf("op %02h c%0d stk_op", op, c), stk_op, eop[c]);
      chk($sformatf("op %02h c%0d stk_data", op, c), stk_data, edat[c]);
      chk($sformatf("op %02h c%0d done", op, c), done, (c == len) && (etrap == TrapNone));
      if (c < len) begin
        chk($sformatf("op %02h c%0d trap", op, c), trap, TrapNone);
        @(negedge clk);
      end
    end
    chk($sformatf("op %02h trap", op), trap, etrap);
    chk($sformatf("op %02h cmd_ready", op), cmd_if.cmd_ready, etrap == TrapNone);
    chk($sformatf("op %02h depth", op), sp, mq.size());
    if (mq.size() > 0) chk($sformatf("op %02h tos", op), stk_tos, mq[mq.size()-1]);
    trapped = (etrap != TrapNone);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    stk_clr = 1'b1;
    mq.delete();
    repeat (2) @(negedge clk);
    chk("reset cmd_ready", cmd_if.cmd_ready, 1);
    chk("reset stk_op", stk_op, StkNone);
    chk("reset stk_data", stk_data, 0);
    chk("reset done", done, 0);
    chk("reset trap", trap, TrapNone);
    stk_clr = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]   op;
    logic [W-1:0] imm;
    logic [W-1:0] tos;
    int           depth;
  } vec_t;

  function automatic vec_t v(input logic [7:0] op, input logic [W-1:0] imm,
                             input logic [W-1:0] tos, input int depth);
    vec_t x;
    x.op = op; x.imm = imm; x.tos = tos; x.depth = depth;
    return x;
  endfunction

  logic [7:0] un_ops  [4]  = '{8'h45, 8'h67, 8'h68, 8'h69};
  logic [7:0] bin_ops [20] = '{8'h46, 8'h47, 8'h48, 8'h49, 8'h4A, 8'h4B, 8'h6A, 8'h6B, 8'h6C,
                               8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78,
                               8'h6A, 8'h6B, 8'h74};
  logic [7:0] bad_ops [4]  = '{8'hFF, 8'h6D, 8'h4C, 8'h00};

  initial begin
    vec_t tbl [38];
    logic tr;
    tbl[0]  = v(8'h41, 32'd5, 32'd5, 1);
    tbl[1]  = v(8'h41, 32'd7, 32'd7, 2);
    tbl[2]  = v(8'h6A, 32'd0, 32'd12, 1);
    tbl[3]  = v(8'h41, 32'd3, 32'd3, 2);
    tbl[4]  = v(8'h6B, 32'd0, 32'd9, 1);
    tbl[5]  = v(8'h41, 32'h00F00000, 32'h00F00000, 2);
    tbl[6]  = v(8'h67, 32'd0, 32'd8, 2);
    tbl[7]  = v(8'h1A, 32'd0, 32'd9, 1);
    tbl[8]  = v(8'h41, 32'h00F00000, 32'h00F00000, 2);
    tbl[9]  = v(8'h68, 32'd0, 32'd20, 2);
    tbl[10] = v(8'h1A, 32'd0, 32'd9, 1);
    tbl[11] = v(8'h41, 32'h00F00000, 32'h00F00000, 2);
    tbl[12] = v(8'h69, 32'd0, 32'd4, 2);
    tbl[13] = v(8'h1A, 32'd0, 32'd9, 1);
    tbl[14] = v(8'h41, 32'd0, 32'd0, 2);
    tbl[15] = v(8'h45, 32'd0, 32'd1, 2);
    tbl[16] = v(8'h67, 32'd0, 32'd31, 2);
    tbl[17] = v(8'h1A, 32'd0, 32'd9, 1);
    tbl[18] = v(8'h41, 32'd1, 32'd1, 2);
    tbl[19] = v(8'h41, 32'd33, 32'd33, 3);
    tbl[20] = v(8'h74, 32'd0, 32'd2, 2);
    tbl[21] = v(8'h1A, 32'd0, 32'd9, 1);
    tbl[22] = v(8'h41, 32'h80000000, 32'h80000000, 2);
    tbl[23] = v(8'h41, 32'd4, 32'd4, 3);
    tbl[24] = v(8'h75, 32'd0, 32'hF8000000, 2);
    tbl[25] = v(8'h1A, 32'd0, 32'd9, 1);
    tbl[26] = v(8'h41, 32'd1, 32'd1, 2);
    tbl[27] = v(8'h41, 32'd1, 32'd1, 3);
    tbl[28] = v(8'h78, 32'd0, 32'h80000000, 2);
    tbl[29] = v(8'h1A, 32'd0, 32'd9, 1);
    tbl[30] = v(8'h41, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    tbl[31] = v(8'h41, 32'd1, 32'd1, 3);
    tbl[32] = v(8'h48, 32'd0, 32'd1, 2);
    tbl[33] = v(8'h1A, 32'd0, 32'd9, 1);
    tbl[34] = v(8'h1A, 32'd0, 32'd0, 0);
    tbl[35] = v(8'h41, 32'd0, 32'd0, 1);
    tbl[36] = v(8'h67, 32'd0, 32'd32, 1);
    tbl[37] = v(8'h1A, 32'd0, 32'd0, 0);

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = '0;
    cmd_if.cmd_imm   = '0;
    do_reset();

    for (int i = 0; i < 38; i++) begin
      run_cmd(tbl[i].op, tbl[i].imm, tr);
      chk($sformatf("vec %0d trapped", i), tr, 0);
      chk($sformatf("vec %0d depth", i), sp, tbl[i].depth);
      if (tbl[i].depth > 0) chk($sformatf("vec %0d tos", i), stk_tos, tbl[i].tos);
    end

    // Binary op with a single operand: pop, restore, underflow trap, then locked out
    do_reset();
    run_cmd(8'h41, 32'd9, tr);
    run_cmd(8'h6A, 32'd0, tr);
    chk("restore trap", trap, TrapUnderflow);
    chk("restore tos", stk_tos, 32'd9);
    chk("restore depth", sp, 1);
    repeat (5) begin
      @(negedge clk);
      chk("trapped cmd_ready", cmd_if.cmd_ready, 0);
      chk("trapped done", done, 0);
    end

    // Overflow: const onto a full stack
    do_reset();
    for (int i = 0; i < DEPTH; i++) run_cmd(8'h41, 32'(i + 100), tr);
    run_cmd(8'h41, 32'hDEAD, tr);
    repeat (3) begin
      @(negedge clk);
      chk("overflow done", done, 0);
      chk("overflow trap", trap, TrapOverflow);
    end
    chk("overflow depth", sp, DEPTH);

    // Illegal opcode
    do_reset();
    run_cmd(8'hFF, 32'd0, tr);
    chk("illegal trap", trap, TrapIllegal);

    // Multiply, legal only with the optional feature
    do_reset();
    run_cmd(8'h41, 32'hFFFFFFFF, tr);
    run_cmd(8'h41, 32'd2, tr);
    run_cmd(8'h6C, 32'd0, tr);
`ifdef STACK_ALU_MUL_EN
    chk("mul tos", stk_tos, 32'hFFFFFFFE);
    chk("mul trap", trap, TrapNone);
`else
    chk("mul trap", trap, TrapIllegal);
    chk("mul depth", sp, 2);
`endif

    // Reset while in EXEC: outputs drop to idle values immediately
    do_reset();
    run_cmd(8'h41, 32'd1, tr);
    run_cmd(8'h41, 32'd2, tr);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 8'h6A;
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    chk("rst_exec pop", stk_op, StkPop);
    @(negedge clk);
    chk("rst_exec replace", stk_op, StkReplace);
    rst_n = 1'b0;
    #1;
    chk("rst_exec stk_op", stk_op, StkNone);
    chk("rst_exec stk_data", stk_data, 0);
    chk("rst_exec trap", trap, TrapNone);
    chk("rst_exec ready", cmd_if.cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_exec depth", sp, 1);
    chk("rst_exec tos", stk_tos, 32'd1);
    mq.delete();
    mq.push_back(32'd1);
    @(negedge clk);
    run_cmd(8'h41, 32'd4, tr);
    run_cmd(8'h6B, 32'd0, tr);
    chk("after_rst sub", stk_tos, 32'hFFFFFFFD);

    // Randomized command stream against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      int           r = $urandom_range(0, 99);
      logic [7:0]   op;
      logic [W-1:0] imm = '0;
      if (r < 40) begin
        op  = 8'h41;
        imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      end else if (r < 50) op = 8'h1A;
      else if (r < 62) op = un_ops[$urandom_range(0, 3)];
      else if (r < 96) op = bin_ops[$urandom_range(0, 19)];
      else op = bad_ops[$urandom_range(0, 3)];
      run_cmd(op, imm, tr);
      if (tr) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
